// File: rtl/multiport_regfile_if.sv
// rtl/multiport_regfile_if.sv - write/read/PC/scoreboard bus of the multiport register file
interface multiport_regfile_if #(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int NRD    = 3,
  parameter int AW     = $clog2(NREG)
);
  logic                  we0;
  logic [AW-1:0]         waddr0;
  logic [DATA_W-1:0]     wdata0;
  logic                  we1;
  logic [AW-1:0]         waddr1;
  logic [DATA_W-1:0]     wdata1;
  logic                  link_we;
  logic                  pc_en;
  logic [DATA_W-1:0]     pc_in;
  logic [DATA_W-1:0]     pc_out;
  logic [NRD-1:0]        rd_en;
  logic [NRD*AW-1:0]     raddr;
  logic [NRD*DATA_W-1:0] rdata;
  logic                  ld_issue;
  logic [AW-1:0]         ld_addr;
  logic [NREG-1:0]       busy;
  logic                  stall;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, link_we, pc_en, pc_in,
           rd_en, raddr, ld_issue, ld_addr,
    input  pc_out, rdata, busy, stall
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, link_we, pc_en, pc_in,
           rd_en, raddr, ld_issue, ld_addr,
    output pc_out, rdata, busy, stall
  );
endinterface

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - register file with PC/LR, write-through reads and load scoreboard
module multiport_regfile #(
  parameter int DATA_W    = 32,
  parameter int NREG      = 16,
  parameter int NRD       = 3,
  parameter int PC_OFFSET = 8,
  parameter int PC_STEP   = 4,
  parameter int AW        = $clog2(NREG)
) (
  input logic                clk,
  input logic                reset,
  multiport_regfile_if.slave bus
);
  localparam logic [AW-1:0] PC_IDX = AW'(NREG - 1);

  logic [DATA_W-1:0]     regs     [NREG];
  logic [DATA_W-1:0]     regs_nxt [NREG];
  logic [DATA_W-1:0]     pc;
  logic [DATA_W-1:0]     link_val;
  logic [DATA_W-1:0]     pc_rd;
  logic [NREG-1:0]       busy_q;
  logic [NREG-1:0]       busy_nxt;
  logic [NRD*DATA_W-1:0] rdata_q;
  logic [NRD*DATA_W-1:0] rdata_nxt;
  logic                  stall_c;
  logic [AW-1:0]         addr;

  assign pc       = regs[NREG-1];
  assign link_val = pc + DATA_W'(PC_STEP);
  assign pc_rd    = pc + DATA_W'(PC_OFFSET);

  // Lowest priority applied first so later assignments win: pc_en, we1, we0, link_we.
  always_comb begin
    for (int a = 0; a < NREG; a++) begin
      regs_nxt[a] = regs[a];
      if (a == NREG - 1 && bus.pc_en) regs_nxt[a] = bus.pc_in;
      if (bus.we1 && bus.waddr1 == AW'(a)) regs_nxt[a] = bus.wdata1;
      if (bus.we0 && bus.waddr0 == AW'(a)) regs_nxt[a] = bus.wdata0;
      if (a == NREG - 2 && bus.link_we) regs_nxt[a] = link_val;
    end
  end

  // Reads of non-PC registers see regs_nxt, which is exactly the write-through bypass.
  always_comb begin
    rdata_nxt = rdata_q;
    stall_c   = 1'b0;
    addr      = '0;
    for (int i = 0; i < NRD; i++) begin
      addr = bus.raddr[i*AW +: AW];
      if (bus.rd_en[i]) begin
        rdata_nxt[i*DATA_W +: DATA_W] = (addr == PC_IDX) ? pc_rd : regs_nxt[addr];
        if (busy_q[addr] && !(bus.we1 && bus.waddr1 == addr)) stall_c = 1'b1;
      end
    end
  end

  // Set after clear so a same-cycle issue and return leaves the register pending.
  always_comb begin
    busy_nxt = busy_q;
    if (bus.we1) busy_nxt[bus.waddr1] = 1'b0;
    if (bus.ld_issue && bus.ld_addr != PC_IDX) busy_nxt[bus.ld_addr] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int a = 0; a < NREG; a++) regs[a] <= '0;
      busy_q  <= '0;
      rdata_q <= '0;
    end else begin
      for (int a = 0; a < NREG; a++) regs[a] <= regs_nxt[a];
      busy_q  <= busy_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  assign bus.pc_out = pc;
  assign bus.rdata  = rdata_q;
  assign bus.busy   = busy_q;
  assign bus.stall  = stall_c;
endmodule

// File: tb/tb_multiport_regfile.sv
// tb/tb_multiport_regfile.sv - directed self-checking bench for multiport_regfile
module tb_multiport_regfile;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  multiport_regfile_if #(.DATA_W(32), .NREG(16), .NRD(3)) bus ();

  multiport_regfile #(.DATA_W(32), .NREG(16), .NRD(3), .PC_OFFSET(8), .PC_STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.we0 = 0; bus.waddr0 = 0; bus.wdata0 = 0;
    bus.we1 = 0; bus.waddr1 = 0; bus.wdata1 = 0;
    bus.link_we = 0; bus.pc_en = 0; bus.pc_in = 0;
    bus.rd_en = 0; bus.raddr = 0;
    bus.ld_issue = 0; bus.ld_addr = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    #12;
    check("reset_pc", bus.pc_out, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_stall", bus.stall, 0);
    check("reset_rdata", bus.rdata, 0);
    reset = 1'b0;

    bus.pc_en = 1; bus.pc_in = 32'h100;
    step();
    check("pc_load", bus.pc_out, 32'h100);

    bus.we0 = 1; bus.waddr0 = 3; bus.wdata0 = 32'hA5A5A5A5;
    bus.rd_en = 3'b011; bus.raddr[3:0] = 3; bus.raddr[7:4] = 15;
    step();
    check("bypass_r3", bus.rdata[31:0], 32'hA5A5A5A5);
    check("pc_read", bus.rdata[63:32], 32'h108);
    check("port2_idle", bus.rdata[95:64], 0);

    bus.we0 = 1; bus.waddr0 = 5; bus.wdata0 = 32'h11;
    bus.we1 = 1; bus.waddr1 = 5; bus.wdata1 = 32'h22;
    step();
    bus.rd_en = 3'b001; bus.raddr[3:0] = 5;
    step();
    check("collision_r5", bus.rdata[31:0], 32'h11);

    bus.rd_en = 3'b000; bus.raddr[3:0] = 3;
    step();
    check("rd_hold", bus.rdata[31:0], 32'h11);

    bus.pc_en = 1; bus.pc_in = 32'h200;
    step();
    bus.link_we = 1; bus.we0 = 1; bus.waddr0 = 14; bus.wdata0 = 32'hDEAD;
    bus.rd_en = 3'b001; bus.raddr[3:0] = 14;
    step();
    check("link_bypass", bus.rdata[31:0], 32'h204);
    bus.rd_en = 3'b010; bus.raddr[7:4] = 14;
    step();
    check("link_wins", bus.rdata[63:32], 32'h204);

    bus.ld_issue = 1; bus.ld_addr = 7;
    step();
    check("ld_busy7", bus.busy, 16'h0080);
    bus.rd_en = 3'b100; bus.raddr[11:8] = 7;
    #1;
    check("stall_set", bus.stall, 1);
    bus.we1 = 1; bus.waddr1 = 7; bus.wdata1 = 32'h55;
    #1;
    check("stall_release", bus.stall, 0);
    step();
    check("ld_return", bus.rdata[95:64], 32'h55);
    check("busy_clear", bus.busy, 0);

    bus.ld_issue = 1; bus.ld_addr = 9;
    bus.we1 = 1; bus.waddr1 = 9; bus.wdata1 = 32'h9;
    step();
    check("set_wins", bus.busy, 16'h0200);
    bus.ld_issue = 1; bus.ld_addr = 15;
    step();
    check("ld_pc_ignored", bus.busy, 16'h0200);
    bus.we0 = 1; bus.waddr0 = 9; bus.wdata0 = 32'h99;
    step();
    check("we0_keeps_busy", bus.busy, 16'h0200);

    bus.pc_en = 1; bus.pc_in = 32'h40;
    bus.we0 = 1; bus.waddr0 = 15; bus.wdata0 = 32'h80;
    step();
    check("we0_over_pc_en", bus.pc_out, 32'h80);
    bus.pc_en = 1; bus.pc_in = 32'hFFFFFFFC; bus.link_we = 1;
    step();
    check("pc_wrap_load", bus.pc_out, 32'hFFFFFFFC);
    bus.rd_en = 3'b011; bus.raddr[3:0] = 14; bus.raddr[7:4] = 15;
    step();
    check("lr_link", bus.rdata[31:0], 32'h84);
    check("pc_read_wrap", bus.rdata[63:32], 32'h4);

    bus.ld_issue = 1; bus.ld_addr = 3;
    bus.we0 = 1; bus.waddr0 = 2; bus.wdata0 = 32'h7;
    step();
    check("pre_reset_busy", bus.busy, 16'h0208);
    bus.rd_en = 3'b001; bus.raddr[3:0] = 3;
    #1;
    check("pre_reset_stall", bus.stall, 1);
    #1;
    reset = 1'b1;
    #1;
    check("async_busy", bus.busy, 0);
    check("async_stall", bus.stall, 0);
    check("async_pc", bus.pc_out, 0);
    check("async_rdata", bus.rdata, 0);
    bus.we0 = 1; bus.waddr0 = 2; bus.wdata0 = 32'hFF;
    bus.pc_en = 1; bus.pc_in = 32'h123;
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    check("reset_ignores_pc", bus.pc_out, 0);
    bus.rd_en = 3'b001; bus.raddr[3:0] = 2;
    step();
    check("r2_cleared", bus.rdata[31:0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/multiport_regfile.md
MULTIPORT_REGFILE -- requirements
Module: multiport_regfile

Interface
REQ-001 Parameters SHALL be:
- DATA_W, default 32, register width.
- NREG, default 16, register count (power of 2, >=4); index NREG-1 is PC, index NREG-2 is LR.
- NRD, default 3, number of read ports.
- PC_OFFSET, default 8, added to PC on PC reads.
- PC_STEP, default 4, link increment.
- AW = log2(NREG), derived.

REQ-002 Ports SHALL be (name, direction, width, meaning); one clock, reset asynchronous and active-high:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- we0  in  1  write enable, port 0 (ALU result).
- waddr0  in  AW  write address, port 0.
- wdata0  in  DATA_W  write data, port 0.
- we1  in  1  write enable, port 1 (load return).
- waddr1  in  AW  write address, port 1.
- wdata1  in  DATA_W  write data, port 1.
- link_we  in  1  write PC+PC_STEP into LR.
- pc_en  in  1  load PC from pc_in.
- pc_in  in  DATA_W  next PC value.
- pc_out  out  DATA_W  current PC register.
- rd_en  in  NRD  per-port read enable.
- raddr  in  NRD*AW  packed read addresses; port i at bits [i*AW +: AW].
- rdata  out  NRD*DATA_W  packed registered read data.
- ld_issue  in  1  mark ld_addr pending.
- ld_addr  in  AW  destination of issued load.
- busy  out  NREG  scoreboard bits.
- stall  out  1  a read hits a pending register.

Function
REQ-003 Storage SHALL be NREG x DATA_W flops; all writes, PC updates and scoreboard updates SHALL occur on the rising clk edge.
REQ-004 Write priority per address, highest first:
- link_we (LR only)
- we0
- we1
REQ-005 PC update priority, highest first:
- we0/we1 to address NREG-1 (same order as REQ-004)
- pc_en -> pc_in
- otherwise PC holds.
REQ-006 link_we SHALL write the pre-edge PC + PC_STEP (mod 2^DATA_W) into LR.
REQ-007 Read port i SHALL update rdata[i] one cycle after a cycle with rd_en[i]=1; with rd_en[i]=0 rdata[i] SHALL hold.
REQ-008 Read value selection, in order:
- raddr = NREG-1: pre-edge PC + PC_OFFSET, no bypass.
- raddr matches a same-cycle write: the value that write commits per REQ-004 (write-through bypass).
- otherwise: stored value.
REQ-009 ld_issue SHALL set busy[ld_addr]; ld_issue with ld_addr = NREG-1 SHALL be ignored.
REQ-010 we1 SHALL clear busy[waddr1]; we0 SHALL NOT alter busy.
REQ-011 If ld_issue and we1 target the same address in one cycle, busy SHALL end set (set wins).
REQ-012 stall SHALL be combinational: 1 iff some port i has rd_en[i]=1, busy[raddr_i]=1, and no we1 to raddr_i in the same cycle.
REQ-013 All arithmetic SHALL be DATA_W wide, with overflow wrapping silently.

Reset
REQ-014 While reset=1, asynchronously and independent of clk:
- all registers, PC and rdata SHALL be 0; pc_out SHALL be 0.
- busy SHALL be 0, hence stall SHALL be 0.
REQ-015 Write, read, PC and scoreboard inputs SHALL be ignored while reset=1.
REQ-016 On the first rising edge after reset deasserts, the block SHALL operate normally.
REQ-017 Asserting reset mid-operation SHALL discard pending loads and clear busy immediately.

Verification
REQ-018 Bypass and PC read: we0=1, waddr0=3, wdata0=0xA5A5A5A5, rd_en[0]=1, raddr0=3 in the same cycle -> rdata0=0xA5A5A5A5 next cycle. With PC=0x100, raddr1=NREG-1 -> rdata1=0x108.
REQ-019 Write collision: we0 (0x11) and we1 (0x22) both to r5 -> r5=0x11. Same edge link_we=1, we0 to r14 with PC=0x200 -> r14=0x204.
REQ-020 Scoreboard:
- ld_issue r7 -> busy[7]=1.
- Next cycle, rd_en[2]=1, raddr2=7 -> stall=1.
- Then we1 to r7 with 0x55 and the same read -> stall=0, rdata2=0x55.
REQ-021 PC control: pc_en=1, pc_in=0x40 and we0 to r15 with 0x80 in one cycle -> pc_out=0x80. Then pc_en=1, pc_in=0xFFFFFFFC, link_we=1 -> LR=0x84, pc_out=0xFFFFFFFC. Then read r15 -> rdata=0x00000004 (wrap).
REQ-022 Async reset: busy[3]=1, r2=0x7; reset pulsed between clk edges -> busy=0, stall=0, r2 reads 0, pc_out=0 before any clk edge.
REQ-023 Same-cycle set/clear: ld_issue r9 and we1 r9 in one cycle -> busy[9]=1. ld_issue to r15 -> busy[15]=0.
